// File: rtl/xosera_pkg.sv
// Shared types for the VRAM blit path: address/word types, blit mode and FSM state.
// The line-step helper keeps the wrap-around address arithmetic in one place.
package xosera_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] word_t;

    typedef enum logic {
        BLIT_FILL = 1'b0,
        BLIT_COPY = 1'b1
    } blit_mode_t;

    typedef enum logic [1:0] {
        BLIT_IDLE = 2'd0,
        BLIT_RD   = 2'd1,
        BLIT_WR   = 2'd2,
        BLIT_DONE = 2'd3
    } blit_state_t;

    localparam int BLIT_CHANS = 2;
    localparam int BLIT_SRC   = 0;
    localparam int BLIT_DST   = 1;

    // Next address after one word; the modulo is only applied when leaving a line.
    function automatic addr_t blit_line_step(addr_t addr, addr_t modulo, logic line_end);
        addr_t step_addr;
        step_addr = addr + 16'd1;
        if (line_end) begin
            step_addr = step_addr + modulo;
        end
        return step_addr;
    endfunction

endpackage

// File: rtl/blit_rect_step.sv
// Word/line counters plus the source and destination address steppers of the blitter.
// Loaded from the config at start, advanced once per acknowledged write.
module blit_rect_step
    import xosera_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n_i,
    input  logic  load_i,
    input  logic  step_i,
    input  addr_t src_addr_i,
    input  addr_t dst_addr_i,
    input  addr_t src_mod_i,
    input  addr_t dst_mod_i,
    input  word_t width_i,
    input  word_t lines_i,
    output addr_t src_addr_o,
    output addr_t dst_addr_o,
    output logic  line_end_o,
    output logic  last_o
);

    word_t width_reg;
    word_t lines_reg;
    word_t word_cnt_reg;
    word_t line_cnt_reg;

    addr_t [BLIT_CHANS-1:0] load_addr;
    addr_t [BLIT_CHANS-1:0] load_mod;
    addr_t [BLIT_CHANS-1:0] chan_addr;

    assign load_addr = {dst_addr_i, src_addr_i};
    assign load_mod  = {dst_mod_i, src_mod_i};

    assign line_end_o = (word_cnt_reg == width_reg);
    // Last line reached; the engine combines this with line_end_o to finish.
    assign last_o     = (line_cnt_reg == lines_reg);

    assign src_addr_o = chan_addr[BLIT_SRC];
    assign dst_addr_o = chan_addr[BLIT_DST];

    generate
        for (genvar gi = 0; gi < BLIT_CHANS; gi++) begin : g_chan
            addr_t addr_reg;
            addr_t mod_reg;
            addr_t addr_next;

            assign addr_next     = blit_line_step(addr_reg, mod_reg, line_end_o);
            assign chan_addr[gi] = addr_reg;

            always_ff @(posedge clk) begin
                if (!reset_n_i) begin
                    addr_reg <= '0;
                    mod_reg  <= '0;
                end else if (load_i) begin
                    addr_reg <= load_addr[gi];
                    mod_reg  <= load_mod[gi];
                end else if (step_i) begin
                    addr_reg <= addr_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            width_reg    <= '0;
            lines_reg    <= '0;
            word_cnt_reg <= '0;
            line_cnt_reg <= '0;
        end else if (load_i) begin
            width_reg    <= width_i;
            lines_reg    <= lines_i;
            word_cnt_reg <= '0;
            line_cnt_reg <= '0;
        end else if (step_i) begin
            if (line_end_o) begin
                word_cnt_reg <= '0;
                line_cnt_reg <= line_cnt_reg + 16'd1;
            end else begin
                word_cnt_reg <= word_cnt_reg + 16'd1;
            end
        end
    end

endmodule

// File: rtl/blit_rect_engine.sv
// Rectangle fill/copy initiator on the arbiter's blit port.
// Request fields are decoded from registered state, so they stay stable until acked.
module blit_rect_engine
    import xosera_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  blit_mode_t mode_i,
    input  addr_t      src_addr_i,
    input  addr_t      dst_addr_i,
    input  addr_t      src_mod_i,
    input  addr_t      dst_mod_i,
    input  word_t      width_i,
    input  word_t      lines_i,
    input  word_t      fill_data_i,
    input  logic [3:0] wr_mask_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       blit_sel_o,
    input  logic       blit_ack_i,
    output logic       blit_wr_o,
    output logic [3:0] blit_wr_mask_o,
    output addr_t      blit_addr_o,
    output word_t      blit_data_o,
    input  word_t      vram_data_i
);

    blit_state_t state_reg;
    blit_state_t state_next;

    blit_mode_t  mode_reg;
    word_t       fill_reg;
    word_t       data_reg;
    logic [3:0]  mask_reg;

    logic        load;
    logic        step;
    logic        data_ld;
    addr_t       src_addr;
    addr_t       dst_addr;
    logic        line_end;
    logic        last_line;

    blit_rect_step u_step (
        .clk        (clk),
        .reset_n_i  (reset_n_i),
        .load_i     (load),
        .step_i     (step),
        .src_addr_i (src_addr_i),
        .dst_addr_i (dst_addr_i),
        .src_mod_i  (src_mod_i),
        .dst_mod_i  (dst_mod_i),
        .width_i    (width_i),
        .lines_i    (lines_i),
        .src_addr_o (src_addr),
        .dst_addr_o (dst_addr),
        .line_end_o (line_end),
        .last_o     (last_line)
    );

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_reg <= BLIT_IDLE;
            mode_reg  <= BLIT_FILL;
            fill_reg  <= '0;
            mask_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                mode_reg <= mode_i;
                fill_reg <= fill_data_i;
                mask_reg <= wr_mask_i;
            end
            if (data_ld) begin
                data_reg <= vram_data_i;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        load           = 1'b0;
        step           = 1'b0;
        data_ld        = 1'b0;
        busy_o         = 1'b1;
        done_o         = 1'b0;
        blit_sel_o     = 1'b0;
        blit_wr_o      = 1'b0;
        blit_wr_mask_o = '0;
        blit_addr_o    = '0;
        blit_data_o    = '0;

        case (state_reg)
            BLIT_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    load       = 1'b1;
                    state_next = (mode_i == BLIT_COPY) ? BLIT_RD : BLIT_WR;
                end
            end
            BLIT_RD: begin
                blit_sel_o  = 1'b1;
                blit_addr_o = src_addr;
                if (blit_ack_i) begin
                    data_ld    = 1'b1;
                    state_next = BLIT_WR;
                end
            end
            BLIT_WR: begin
                blit_sel_o     = 1'b1;
                blit_wr_o      = 1'b1;
                blit_wr_mask_o = mask_reg;
                blit_addr_o    = dst_addr;
                blit_data_o    = (mode_reg == BLIT_COPY) ? data_reg : fill_reg;
                if (blit_ack_i) begin
                    step = 1'b1;
                    if (line_end && last_line) begin
                        state_next = BLIT_DONE;
                    end else if (mode_reg == BLIT_COPY) begin
                        state_next = BLIT_RD;
                    end else begin
                        state_next = BLIT_WR;
                    end
                end
            end
            BLIT_DONE: begin
                done_o     = 1'b1;
                state_next = BLIT_IDLE;
            end
            default: begin
                state_next = BLIT_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_blit_rect_engine.sv
// Bench for blit_rect_engine: an arbiter/VRAM model logs every granted access,
// and each scenario compares that log against a rectangle-level reference model.
module tb_blit_rect_engine;
    import xosera_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n_i;
    logic        start_i;
    blit_mode_t  mode_i;
    logic [15:0] src_addr_i, dst_addr_i, src_mod_i, dst_mod_i;
    logic [15:0] width_i, lines_i, fill_data_i;
    logic [3:0]  wr_mask_i;
    logic        busy_o, done_o, blit_sel_o, blit_ack_i, blit_wr_o;
    logic [3:0]  blit_wr_mask_o;
    logic [15:0] blit_addr_o, blit_data_o, vram_data_i;

    blit_rect_engine dut (
        .clk            (clk),
        .reset_n_i      (reset_n_i),
        .start_i        (start_i),
        .mode_i         (mode_i),
        .src_addr_i     (src_addr_i),
        .dst_addr_i     (dst_addr_i),
        .src_mod_i      (src_mod_i),
        .dst_mod_i      (dst_mod_i),
        .width_i        (width_i),
        .lines_i        (lines_i),
        .fill_data_i    (fill_data_i),
        .wr_mask_i      (wr_mask_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .blit_sel_o     (blit_sel_o),
        .blit_ack_i     (blit_ack_i),
        .blit_wr_o      (blit_wr_o),
        .blit_wr_mask_o (blit_wr_mask_o),
        .blit_addr_o    (blit_addr_o),
        .blit_data_o    (blit_data_o),
        .vram_data_i    (vram_data_i)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0]  mask;
    } txn_t;

    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [15:0] mem     [65536];
    logic [15:0] ref_mem [65536];
    int          stall_cycles = 0;
    int          stable_err   = 0;
    int          done_count   = 0;
    int          n_checks     = 0;
    int          n_fail       = 0;

    function automatic logic [15:0] merge_word(logic [15:0] old_w, logic [15:0] new_w, logic [3:0] mask);
        logic [15:0] r;
        r = old_w;
        for (int n = 0; n < 4; n++)
            if (mask[n]) r[n*4 +: 4] = new_w[n*4 +: 4];
        return r;
    endfunction

    // Arbiter + VRAM: grants a held request after stall_cycles, acks for one cycle,
    // ignores sel during its own ack cycle, and logs what was granted.
    initial begin : arbiter
        bit   pending;
        int   wait_left;
        txn_t cap;
        pending = 0; wait_left = 0;
        blit_ack_i = 1'b0; vram_data_i = '0;
        forever begin
            @(posedge clk); #1;
            if (done_o) done_count++;
            if (blit_ack_i) begin
                blit_ack_i = 1'b0;
                vram_data_i = '0;
            end
            if (pending) begin
                if (blit_sel_o && (blit_wr_o !== cap.wr || blit_addr_o !== cap.addr ||
                                   blit_data_o !== cap.data || blit_wr_mask_o !== cap.mask))
                    stable_err++;
                if (wait_left == 0) begin
                    pending = 0;
                    blit_ack_i = 1'b1;
                    if (cap.wr) mem[cap.addr] = merge_word(mem[cap.addr], cap.data, cap.mask);
                    else begin
                        vram_data_i = mem[cap.addr];
                        cap.data = mem[cap.addr];
                    end
                    log_q.push_back(cap);
                    $display("txn %s addr=%h data=%h mask=%h t=%0t", cap.wr ? "WR" : "RD",
                             cap.addr, cap.data, cap.mask, $time);
                end else begin
                    wait_left--;
                end
            end else if (blit_sel_o) begin
                cap = '{blit_wr_o, blit_addr_o, blit_data_o, blit_wr_mask_o};
                pending = 1;
                wait_left = stall_cycles;
            end
        end
    end

    // Reference: word (l,w) lives at start + l*(width+1+mod) + w, modulo 2^16.
    task automatic model_blit(input blit_mode_t m, input logic [15:0] src, input logic [15:0] dst,
                              input logic [15:0] smod, input logic [15:0] dmod, input logic [15:0] w,
                              input logic [15:0] l, input logic [15:0] fill, input logic [3:0] mask);
        exp_q.delete();
        ref_mem = mem;
        for (int li = 0; li <= int'(l); li++) begin
            for (int wi = 0; wi <= int'(w); wi++) begin
                logic [15:0] s, d, v;
                s = src + 16'(li) * (w + 16'd1 + smod) + 16'(wi);
                d = dst + 16'(li) * (w + 16'd1 + dmod) + 16'(wi);
                v = fill;
                if (m == BLIT_COPY) begin
                    v = ref_mem[s];
                    exp_q.push_back(txn_t'{1'b0, s, v, 4'h0});
                end
                exp_q.push_back(txn_t'{1'b1, d, v, mask});
                ref_mem[d] = merge_word(ref_mem[d], v, mask);
            end
        end
    endtask

    task automatic start_blit(input blit_mode_t m, input logic [15:0] src, input logic [15:0] dst,
                              input logic [15:0] smod, input logic [15:0] dmod, input logic [15:0] w,
                              input logic [15:0] l, input logic [15:0] fill, input logic [3:0] mask);
        log_q.delete();
        done_count = 0;
        stable_err = 0;
        @(negedge clk);
        mode_i = m; src_addr_i = src; dst_addr_i = dst; src_mod_i = smod; dst_mod_i = dmod;
        width_i = w; lines_i = l; fill_data_i = fill; wr_mask_i = mask; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        mode_i = blit_mode_t'($urandom_range(0, 1));
        src_addr_i = 16'($urandom); dst_addr_i = 16'($urandom);
        src_mod_i = 16'($urandom); dst_mod_i = 16'($urandom);
        width_i = 16'($urandom); lines_i = 16'($urandom);
        fill_data_i = 16'($urandom); wr_mask_i = 4'($urandom);
    endtask

    task automatic wait_idle(input int max_cycles, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_checks++; if (blit_sel_o !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0", blit_sel_o); end
        n_checks++; if (blit_wr_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", blit_wr_o); end
        n_checks++; if (blit_wr_mask_o !== 4'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", blit_wr_mask_o); end
        n_checks++; if (blit_addr_o !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", blit_addr_o); end
        n_checks++; if (blit_data_o !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", blit_data_o); end
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fill_basic();
        bit to;
        stall_cycles = 0;
        model_blit(BLIT_FILL, 16'h0, 16'h1000, 16'h0, 16'd4, 16'd3, 16'd1, 16'hA5A5, 4'hF);
        start_blit(BLIT_FILL, 16'h0, 16'h1000, 16'h0, 16'd4, 16'd3, 16'd1, 16'hA5A5, 4'hF);
        wait_idle(200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL fill_timeout: busy stuck high"); end
        n_checks++; if (log_q.size() != 8) begin n_fail++; $display("FAIL fill_count: got %0d want 8", log_q.size()); end
        n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL fill_done: got %0d pulses want 1", done_count); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data ||
                (exp_q[i].wr && log_q[i].mask !== exp_q[i].mask)) begin
                n_fail++;
                $display("FAIL fill_txn[%0d]: got wr=%0b addr=%h data=%h mask=%h want wr=%0b addr=%h data=%h mask=%h", i,
                         log_q[i].wr, log_q[i].addr, log_q[i].data, log_q[i].mask,
                         exp_q[i].wr, exp_q[i].addr, exp_q[i].data, exp_q[i].mask);
            end
        end
    endtask

    task automatic test_copy_basic();
        bit to;
        stall_cycles = 0;
        mem[16'h2000] = 16'h1111;
        mem[16'h2001] = 16'h2222;
        model_blit(BLIT_COPY, 16'h2000, 16'h3000, 16'h0, 16'h0, 16'd1, 16'd0, 16'h0, 4'hF);
        start_blit(BLIT_COPY, 16'h2000, 16'h3000, 16'h0, 16'h0, 16'd1, 16'd0, 16'h0, 4'hF);
        wait_idle(200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL copy_timeout: busy stuck high"); end
        n_checks++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL copy_count: got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data ||
                (exp_q[i].wr && log_q[i].mask !== exp_q[i].mask)) begin
                n_fail++;
                $display("FAIL copy_txn[%0d]: got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h", i,
                         log_q[i].wr, log_q[i].addr, log_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_checks++; if (mem[16'h3000] !== 16'h1111) begin n_fail++; $display("FAIL copy_mem0: got %h want 1111", mem[16'h3000]); end
        n_checks++; if (mem[16'h3001] !== 16'h2222) begin n_fail++; $display("FAIL copy_mem1: got %h want 2222", mem[16'h3001]); end
    endtask

    task automatic test_stall();
        bit to;
        stall_cycles = 5;
        model_blit(BLIT_COPY, 16'h2100, 16'h2102, 16'd3, 16'hFFFE, 16'd2, 16'd1, 16'h0, 4'h6);
        start_blit(BLIT_COPY, 16'h2100, 16'h2102, 16'd3, 16'hFFFE, 16'd2, 16'd1, 16'h0, 4'h6);
        wait_idle(500, to);
        stall_cycles = 0;
        n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout: busy stuck high"); end
        n_checks++; if (stable_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d field changes want 0", stable_err); end
        n_checks++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data ||
                (exp_q[i].wr && log_q[i].mask !== exp_q[i].mask)) begin
                n_fail++;
                $display("FAIL stall_txn[%0d]: got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h", i,
                         log_q[i].wr, log_q[i].addr, log_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_wrap();
        bit to;
        logic [15:0] want_addr [4];
        want_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        stall_cycles = 0;
        start_blit(BLIT_FILL, 16'h0, 16'hFFFE, 16'h0, 16'h0, 16'd3, 16'd0, 16'h0F0F, 4'hF);
        wait_idle(200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL wrap_timeout: busy stuck high"); end
        n_checks++; if (log_q.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", log_q.size()); end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i].addr !== want_addr[i] || log_q[i].wr !== 1'b1 || log_q[i].data !== 16'h0F0F) begin
                n_fail++;
                $display("FAIL wrap_txn[%0d]: got wr=%0b addr=%h data=%h want wr=1 addr=%h data=0f0f", i,
                         log_q[i].wr, log_q[i].addr, log_q[i].data, want_addr[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int guard;
        stall_cycles = 0;
        start_blit(BLIT_FILL, 16'h0, 16'h4000, 16'h0, 16'h0, 16'd7, 16'd0, 16'h5A5A, 4'hF);
        guard = 0;
        while (!(blit_sel_o && blit_wr_o && blit_addr_o == 16'h4002) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (guard >= 50) begin n_fail++; $display("FAIL rstmid_reach: third write never presented"); end
        reset_n_i = 1'b0;
        @(negedge clk);
        reset_n_i = 1'b1;
        n_checks++; if (blit_sel_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_sel: got %b want 0", blit_sel_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy_o !== 1'b0 || done_count != 0) begin n_fail++; $display("FAIL rstmid_lateack: got busy=%b done=%0d want 0/0", busy_o, done_count); end
        model_blit(BLIT_FILL, 16'h0, 16'h4000, 16'h0, 16'h0, 16'd7, 16'd0, 16'h1234, 4'hF);
        start_blit(BLIT_FILL, 16'h0, 16'h4000, 16'h0, 16'h0, 16'd7, 16'd0, 16'h1234, 4'hF);
        wait_idle(200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_timeout: busy stuck high"); end
        n_checks++; if (log_q.size() != exp_q.size() || done_count != 1) begin n_fail++; $display("FAIL rstmid_count: got %0d txns %0d done want %0d txns 1 done", log_q.size(), done_count, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL rstmid_txn[%0d]: got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h", i,
                         log_q[i].wr, log_q[i].addr, log_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        int guard;
        stall_cycles = 0;
        start_blit(BLIT_FILL, 16'h0, 16'h5000, 16'h0, 16'h0, 16'd0, 16'd0, 16'hBEEF, 4'h3);
        start_i = 1'b1;
        guard = 0;
        while (!done_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        start_i = 1'b0;
        wait_idle(200, to);
        repeat (4) @(negedge clk);
        n_checks++; if (guard >= 50 || to) begin n_fail++; $display("FAIL ignore_timeout: done never seen"); end
        n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL ignore_done: got %0d pulses want 1", done_count); end
        n_checks++; if (log_q.size() != 1) begin n_fail++; $display("FAIL ignore_count: got %0d txns want 1", log_q.size()); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got %b want 0", busy_o); end
        if (log_q.size() > 0) begin
            n_checks++;
            if (log_q[0].wr !== 1'b1 || log_q[0].addr !== 16'h5000 || log_q[0].data !== 16'hBEEF || log_q[0].mask !== 4'h3) begin
                n_fail++;
                $display("FAIL ignore_txn: got wr=%0b addr=%h data=%h mask=%h want wr=1 addr=5000 data=beef mask=3",
                         log_q[0].wr, log_q[0].addr, log_q[0].data, log_q[0].mask);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        for (int r = 0; r < 8; r++) begin
            blit_mode_t  m;
            logic [15:0] src, dst, smod, dmod, w, l, fill;
            logic [3:0]  mask;
            m    = blit_mode_t'($urandom_range(0, 1));
            src  = 16'($urandom); dst = 16'($urandom);
            smod = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 8));
            dmod = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 8));
            w    = 16'($urandom_range(0, 4));
            l    = 16'($urandom_range(0, 3));
            fill = 16'($urandom);
            mask = 4'($urandom);
            stall_cycles = $urandom_range(0, 3);
            model_blit(m, src, dst, smod, dmod, w, l, fill, mask);
            start_blit(m, src, dst, smod, dmod, w, l, fill, mask);
            wait_idle(1000, to);
            n_checks++; if (to || done_count != 1) begin n_fail++; $display("FAIL rand%0d_done: timeout=%0b done=%0d want 0/1", r, to, done_count); end
            n_checks++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", r, log_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
                n_checks++;
                if (log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data ||
                    (exp_q[i].wr && log_q[i].mask !== exp_q[i].mask)) begin
                    n_fail++;
                    $display("FAIL rand%0d_txn[%0d]: got wr=%0b addr=%h data=%h mask=%h want wr=%0b addr=%h data=%h mask=%h", r, i,
                             log_q[i].wr, log_q[i].addr, log_q[i].data, log_q[i].mask,
                             exp_q[i].wr, exp_q[i].addr, exp_q[i].data, exp_q[i].mask);
                end
            end
        end
        stall_cycles = 0;
    endtask

    initial begin
        reset_n_i = 1'b0; start_i = 1'b0; mode_i = BLIT_FILL;
        src_addr_i = '0; dst_addr_i = '0; src_mod_i = '0; dst_mod_i = '0;
        width_i = '0; lines_i = '0; fill_data_i = '0; wr_mask_i = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        test_reset();
        test_fill_basic();
        test_copy_basic();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
